// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, ALU, branch-target adder and an optional
// iterative shift-add multiplier, with a valid/ready handshake on both sides.
module execute_stage #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] imm,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [4:0]       rd,
  input  logic [3:0]       alu_op,
  input  logic             alu_src,
  input  logic [5:0]       ctrl_in,
  input  logic             fwd_mem_en,
  input  logic [4:0]       fwd_mem_rd,
  input  logic [WIDTH-1:0] fwd_mem_data,
  input  logic             fwd_wb_en,
  input  logic [4:0]       fwd_wb_rd,
  input  logic [WIDTH-1:0] fwd_wb_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] branch_target,
  output logic [WIDTH-1:0] store_data,
  output logic             zero,
  output logic [4:0]       rd_out,
  output logic [5:0]       ctrl_out
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH);

  // state  | meaning
  // IDLE   | no multiply outstanding, single-cycle ops accepted
  // MUL    | one shift-add iteration per edge, WIDTH iterations in total
  // DONE   | product ready, waiting for the output slot to free up
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic [WIDTH-1:0] mul_acc;
  logic [WIDTH-1:0] pend_target;
  logic [WIDTH-1:0] pend_store;
  logic [4:0]       pend_rd;
  logic [5:0]       pend_ctrl;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] rs2_fwd;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] alu_next;
  logic [WIDTH-1:0] target_next;
  logic [SHW-1:0]   shamt;
  logic             busy;
  logic             slot_free;
  logic             accept;
  logic             is_mul;
  logic             mul_wr;

  // MEM beats WB; register 0 is hardwired and never forwarded.
  always_comb begin
    op_a = rs1_data;
    if (fwd_mem_en && fwd_mem_rd == rs1 && rs1 != 5'd0)
      op_a = fwd_mem_data;
    else if (fwd_wb_en && fwd_wb_rd == rs1 && rs1 != 5'd0)
      op_a = fwd_wb_data;

    rs2_fwd = rs2_data;
    if (fwd_mem_en && fwd_mem_rd == rs2 && rs2 != 5'd0)
      rs2_fwd = fwd_mem_data;
    else if (fwd_wb_en && fwd_wb_rd == rs2 && rs2 != 5'd0)
      rs2_fwd = fwd_wb_data;

    op_b = alu_src ? imm : rs2_fwd;
  end

  assign shamt = op_b[SHW-1:0];

  always_comb begin
    alu_next = '0;
    case (alu_op)
      OP_ADD:  alu_next = op_a + op_b;
      OP_SUB:  alu_next = op_a - op_b;
      OP_AND:  alu_next = op_a & op_b;
      OP_OR:   alu_next = op_a | op_b;
      OP_XOR:  alu_next = op_a ^ op_b;
      OP_SLL:  alu_next = op_a << shamt;
      OP_SRL:  alu_next = op_a >> shamt;
      OP_SRA:  alu_next = $unsigned($signed(op_a) >>> shamt);
      OP_SLT:  alu_next = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLTU: alu_next = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
      default: alu_next = '0;
    endcase
  end

  assign target_next = pc + (imm << 1);

  assign busy      = (state != S_IDLE);
  assign slot_free = !out_valid || out_ready;
  assign in_ready  = !busy && slot_free;
  assign accept    = in_valid && in_ready && !flush;
  assign is_mul    = MUL_EN && (alu_op == OP_MUL);
  assign mul_wr    = (state == S_DONE) && slot_free && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      mul_a       <= '0;
      mul_b       <= '0;
      mul_acc     <= '0;
      pend_target <= '0;
      pend_store  <= '0;
      pend_rd     <= '0;
      pend_ctrl   <= '0;
    end else if (flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept && is_mul) begin
            state       <= S_MUL;
            cnt         <= CW'(WIDTH - 1);
            mul_a       <= op_a;
            mul_b       <= op_b;
            mul_acc     <= '0;
            pend_target <= target_next;
            pend_store  <= rs2_fwd;
            pend_rd     <= rd;
            pend_ctrl   <= ctrl_in;
          end
        end
        S_MUL: begin
          mul_acc <= mul_acc + (mul_b[0] ? mul_a : '0);
          mul_a   <= mul_a << 1;
          mul_b   <= mul_b >> 1;
          if (cnt == '0)
            state <= S_DONE;
          else
            cnt <= cnt - CW'(1);
        end
        S_DONE: begin
          if (slot_free)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output slot: written only when free, so a stalled result never changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid     <= 1'b0;
      alu_result    <= '0;
      branch_target <= '0;
      store_data    <= '0;
      zero          <= 1'b1;
      rd_out        <= '0;
      ctrl_out      <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept && !is_mul) begin
      out_valid     <= 1'b1;
      alu_result    <= alu_next;
      branch_target <= target_next;
      store_data    <= rs2_fwd;
      zero          <= (alu_next == '0);
      rd_out        <= rd;
      ctrl_out      <= ctrl_in;
    end else if (mul_wr) begin
      out_valid     <= 1'b1;
      alu_result    <= mul_acc;
      branch_target <= pend_target;
      store_data    <= pend_store;
      zero          <= (mul_acc == '0);
      rd_out        <= pend_rd;
      ctrl_out      <= pend_ctrl;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
